// File: rtl/ogege_pkg.sv
// ogege_pkg: shared constants and types for the text-cell fetch scheduler.
//   - default text grid size (80 x 60 cells of 8 x 8 pixels)
//   - pixel phases inside a character slot at which the display read is
//     issued, its data captured, and the visible cell registers updated
//   - bit positions of the char / fg / bg fields inside a 16-bit cell word
//   - the read-owner tag that says who owns the word returning from RAM
package ogege_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 60;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 8;

    localparam logic [2:0] FETCH_PHASE = 3'd2;
    localparam logic [2:0] LATCH_PHASE = 3'd3;
    localparam logic [2:0] LOAD_PHASE  = 3'd7;

    localparam int CHAR_LSB = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } read_tag_e;

endpackage

// File: rtl/text_fetch_sched_addr_gen.sv
// text_addr_gen: works out which text cell follows the one under the beam.
//   i_hcount / i_vcount : current pixel position from the VGA timing core
//   o_next_addr         : row*COLS+col of the following cell
//   o_next_in_range     : following cell lies inside the COLS x ROWS grid
// Inside a line the next cell is one column to the right on the same row.
// In the last slot of a line it is column 0 of the row holding the next
// line, and the final line of the frame wraps to row 0.
module text_addr_gen
    import ogege_pkg::*;
#(
    parameter int COLS    = DEFAULT_COLS,
    parameter int ROWS    = DEFAULT_ROWS,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int HSZ     = 10,
    parameter int VSZ     = 10,
    parameter int ADDR_W  = 13
) (
    input  logic [HSZ-1:0]    i_hcount,
    input  logic [VSZ-1:0]    i_vcount,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_next_in_range
);

    // One spare bit on each so col+1 past the last column cannot alias.
    localparam int CW = HSZ - 2;
    localparam int RW = VSZ - 2;

    logic [CW-1:0] next_col;
    logic [RW-1:0] next_row;
    logic [VSZ:0]  vnext;

    // Next-cell column/row selection including line and frame wrap.
    always_comb begin
        next_col = '0;
        next_row = '0;
        vnext    = {1'b0, i_vcount} + (VSZ+1)'(1);
        if (i_hcount >= HSZ'(H_TOTAL - CHAR_W)) begin
            next_col = '0;
            if (i_vcount == VSZ'(V_TOTAL - 1)) begin
                next_row = '0;
            end else begin
                next_row = vnext[VSZ:3];
            end
        end else begin
            next_col = {1'b0, i_hcount[HSZ-1:3]} + CW'(1);
            next_row = {1'b0, i_vcount[VSZ-1:3]};
        end
    end

    assign o_next_in_range = (next_col < CW'(COLS)) && (next_row < RW'(ROWS));
    assign o_next_addr     = ADDR_W'(next_row) * ADDR_W'(COLS) + ADDR_W'(next_col);

endmodule

// File: rtl/text_fetch_sched.sv
// text_fetch_sched: arbitrates the single-port text-cell RAM between the
// display path and a host valid/ready port.
//   clk_i, rst_i              : pixel clock, async active-high reset
//   i_hcount, i_vcount        : beam position from the VGA timing core
//   o_ram_addr/we/wdata       : RAM command (combinational, 0 while reset)
//   i_ram_rdata               : RAM data, one clock after the address
//   i_host_*/o_host_ready     : host request channel
//   o_host_rdata/rvalid       : host read return, one clock after accept
//   o_char/o_fg_idx/o_bg_idx  : fields of the cell currently being drawn
//   o_cell_valid              : that cell lies inside the text grid
// The display owns the RAM on phase 2 of each slot (reading the following
// cell); every other cycle belongs to the host.
module text_fetch_sched
    import ogege_pkg::*;
#(
    parameter int COLS    = DEFAULT_COLS,
    parameter int ROWS    = DEFAULT_ROWS,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int HSZ     = 10,
    parameter int VSZ     = 10,
    parameter int ADDR_W  = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [HSZ-1:0]    i_hcount,
    input  logic [VSZ-1:0]    i_vcount,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [15:0]       o_ram_wdata,
    input  logic [15:0]       i_ram_rdata,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [15:0]       i_host_wdata,
    output logic [15:0]       o_host_rdata,
    output logic              o_host_rvalid,
    output logic [7:0]        o_char,
    output logic [3:0]        o_fg_idx,
    output logic [3:0]        o_bg_idx,
    output logic              o_cell_valid
);

    logic [ADDR_W-1:0] next_addr;
    logic              next_in_range;
    logic [2:0]        phase;
    logic              disp_slot;
    logic              host_xfer;
    logic              host_oor;
    read_tag_e         tag;
    read_tag_e         tag_next;
    logic              rd_oor;
    logic [15:0]       pf_data;
    logic              pf_valid;

    text_addr_gen #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HSZ     (HSZ),
        .VSZ     (VSZ),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .i_hcount        (i_hcount),
        .i_vcount        (i_vcount),
        .o_next_addr     (next_addr),
        .o_next_in_range (next_in_range)
    );

    assign phase     = i_hcount[2:0];
    assign host_oor  = (i_host_addr >= ADDR_W'(COLS * ROWS));
    // No display slot for an off-grid next cell: the host keeps that cycle.
    assign disp_slot = !rst_i && (phase == FETCH_PHASE) && next_in_range;
    assign host_xfer = i_host_valid && o_host_ready;

    // RAM port mux: display read, host pass-through, or idle zeros.
    always_comb begin
        o_host_ready = 1'b0;
        o_ram_addr   = '0;
        o_ram_we     = 1'b0;
        o_ram_wdata  = 16'h0000;
        if (rst_i) begin
            o_host_ready = 1'b0;
        end else if (disp_slot) begin
            o_ram_addr = next_addr;
        end else begin
            o_host_ready = 1'b1;
            if (i_host_valid) begin
                o_ram_addr = i_host_addr;
                // Off-grid writes are accepted but never reach the RAM.
                if (i_host_we && !host_oor) begin
                    o_ram_we    = 1'b1;
                    o_ram_wdata = i_host_wdata;
                end else begin
                    o_ram_we    = 1'b0;
                end
            end else begin
                o_ram_addr = '0;
            end
        end
    end

    // Read-owner tag register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag <= TAG_NONE;
        end else begin
            tag <= tag_next;
        end
    end

    // Tag next state: who owns the word coming back next cycle.
    always_comb begin
        tag_next = TAG_NONE;
        if (disp_slot) begin
            tag_next = TAG_DISP;
        end else if (host_xfer && !i_host_we) begin
            tag_next = TAG_HOST;
        end else begin
            tag_next = TAG_NONE;
        end
    end

    // Remembers that the host read in flight was off-grid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_oor <= 1'b0;
        end else begin
            rd_oor <= host_xfer && !i_host_we && host_oor;
        end
    end

    // Host read return steered straight from the RAM data when tagged HOST.
    always_comb begin
        o_host_rvalid = 1'b0;
        o_host_rdata  = 16'h0000;
        case (tag)
            TAG_HOST: begin
                o_host_rvalid = 1'b1;
                if (rd_oor) begin
                    o_host_rdata = 16'h0000;
                end else begin
                    o_host_rdata = i_ram_rdata;
                end
            end
            TAG_DISP, TAG_NONE: begin
                o_host_rvalid = 1'b0;
            end
            default: begin
                o_host_rvalid = 1'b0;
            end
        endcase
    end

    // Prefetch: note at phase 2 whether a fetch was issued, capture at 3.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pf_valid <= 1'b0;
            pf_data  <= 16'h0000;
        end else begin
            if (phase == FETCH_PHASE) begin
                pf_valid <= next_in_range;
            end
            if ((phase == LATCH_PHASE) && (tag == TAG_DISP)) begin
                pf_data <= i_ram_rdata;
            end
        end
    end

    // Visible cell registers change only on the edge ending phase 7.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            o_char       <= 8'h00;
            o_fg_idx     <= 4'h0;
            o_bg_idx     <= 4'h0;
            o_cell_valid <= 1'b0;
        end else if (phase == LOAD_PHASE) begin
            o_cell_valid <= pf_valid;
            if (pf_valid) begin
                o_char   <= pf_data[CHAR_LSB +: 8];
                o_fg_idx <= pf_data[FG_LSB +: 4];
                o_bg_idx <= pf_data[BG_LSB +: 4];
            end else begin
                o_char   <= 8'h00;
                o_fg_idx <= 4'h0;
                o_bg_idx <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_text_fetch_sched.sv
module tb_text_fetch_sched;

    localparam int COLS    = 80;
    localparam int ROWS    = 60;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int NCELLS  = COLS * ROWS;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [9:0]  i_hcount = 10'd0;
    logic [9:0]  i_vcount = 10'd0;
    logic [12:0] o_ram_addr;
    logic        o_ram_we;
    logic [15:0] o_ram_wdata;
    logic [15:0] ram_rdata;
    logic        i_host_valid = 1'b0;
    logic        o_host_ready;
    logic        i_host_we = 1'b0;
    logic [12:0] i_host_addr = 13'd0;
    logic [15:0] i_host_wdata = 16'h0000;
    logic [15:0] o_host_rdata;
    logic        o_host_rvalid;
    logic [7:0]  o_char;
    logic [3:0]  o_fg_idx;
    logic [3:0]  o_bg_idx;
    logic        o_cell_valid;

    text_fetch_sched #(
        .COLS(COLS), .ROWS(ROWS), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .HSZ(10), .VSZ(10), .ADDR_W(13)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .i_hcount(i_hcount), .i_vcount(i_vcount),
        .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we), .o_ram_wdata(o_ram_wdata),
        .i_ram_rdata(ram_rdata), .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
        .i_host_we(i_host_we), .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
        .o_host_rdata(o_host_rdata), .o_host_rvalid(o_host_rvalid), .o_char(o_char),
        .o_fg_idx(o_fg_idx), .o_bg_idx(o_bg_idx), .o_cell_valid(o_cell_valid)
    );

    always #5 clk_i = ~clk_i;

    // The RAM itself (synchronous read, one clock latency).
    logic [15:0] ram [0:8191];
    always @(posedge clk_i) begin
        if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
        ram_rdata <= ram[o_ram_addr];
    end

    // Reference model state.
    int model_mem   [0:8191];
    int fetched_val [0:8191];
    bit exp_rv = 1'b0;
    int exp_rd = 0;
    int arm_cnt = 0;
    int prev_h = 0, prev_v = 0;
    bit have_prev = 1'b0;
    bit stim_acc = 1'b0;
    bit rand_host = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)",
                     name, act, exp, i_hcount, i_vcount, $time);
        end
    endtask

    // Raster position n pixel clocks later.
    function automatic void adv(input int h, input int v, input int n, output int ho, output int vo);
        ho = h + n;
        vo = v;
        if (ho >= H_TOTAL) begin
            ho -= H_TOTAL;
            vo = v + 1;
            if (vo >= V_TOTAL) vo = 0;
        end
    endfunction

    // Linear cell under pixel (h,v), or -1 when outside the text grid.
    function automatic int cell_of(input int h, input int v);
        if ((h / 8) < COLS && (v / 8) < ROWS) return (v / 8) * COLS + (h / 8);
        return -1;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk_i) begin
        int h, v, nh, nv, nc, dc;
        bit exp_ready, acc, wr_ok;
        h = int'(i_hcount);
        v = int'(i_vcount);
        stim_acc = i_host_valid && o_host_ready;
        if (rst_i) begin
            chk("rst_ready",  32'(o_host_ready),  32'd0);
            chk("rst_we",     32'(o_ram_we),      32'd0);
            chk("rst_addr",   32'(o_ram_addr),    32'd0);
            chk("rst_wdata",  32'(o_ram_wdata),   32'd0);
            chk("rst_rvalid", 32'(o_host_rvalid), 32'd0);
            chk("rst_rdata",  32'(o_host_rdata),  32'd0);
            chk("rst_char",   32'(o_char),        32'd0);
            chk("rst_fg",     32'(o_fg_idx),      32'd0);
            chk("rst_bg",     32'(o_bg_idx),      32'd0);
            chk("rst_valid",  32'(o_cell_valid),  32'd0);
            exp_rv = 1'b0;
            arm_cnt = 0;
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                adv(prev_h, prev_v, 1, nh, nv);
                if (nh != h || nv != v) arm_cnt = 0;
            end
            chk("rvalid", 32'(o_host_rvalid), 32'(exp_rv));
            if (exp_rv) chk("rdata", 32'(o_host_rdata), 32'(exp_rd));

            // The display fetches the cell whose slot begins 6 clocks from now.
            adv(h, v, 6, nh, nv);
            nc = cell_of(nh, nv);
            exp_ready = !((h % 8) == 2 && nc >= 0);
            chk("ready", 32'(o_host_ready), 32'(exp_ready));
            acc = i_host_valid && exp_ready;
            wr_ok = acc && i_host_we && (int'(i_host_addr) < NCELLS);
            if (!exp_ready) begin
                chk("disp_addr", 32'(o_ram_addr), 32'(nc));
                chk("disp_we",   32'(o_ram_we),   32'd0);
                fetched_val[nc] = model_mem[nc];
            end else if (acc) begin
                chk("host_addr", 32'(o_ram_addr), 32'(i_host_addr));
                chk("host_we",   32'(o_ram_we),   32'(wr_ok));
                if (wr_ok) chk("host_wdata", 32'(o_ram_wdata), 32'(i_host_wdata));
            end else begin
                chk("idle_we", 32'(o_ram_we), 32'd0);
            end

            if (arm_cnt >= 16) begin
                dc = cell_of(h, v);
                if (dc >= 0) begin
                    chk("char",  32'(o_char),       32'(fetched_val[dc][7:0]));
                    chk("fg",    32'(o_fg_idx),     32'(fetched_val[dc][11:8]));
                    chk("bg",    32'(o_bg_idx),     32'(fetched_val[dc][15:12]));
                    chk("valid", 32'(o_cell_valid), 32'd1);
                end else begin
                    chk("blank_char",  32'(o_char),       32'd0);
                    chk("blank_valid", 32'(o_cell_valid), 32'd0);
                end
            end

            exp_rv = acc && !i_host_we;
            exp_rd = (int'(i_host_addr) < NCELLS) ? model_mem[i_host_addr] : 0;
            if (wr_ok) model_mem[i_host_addr] = int'(i_host_wdata);
            arm_cnt++;
            prev_h = h;
            prev_v = v;
            have_prev = 1'b1;
        end
    end

    task automatic host_gen();
        if (i_host_valid && !stim_acc) begin
            // hold the pending request
        end else if ($urandom_range(0, 99) < 45) begin
            i_host_valid = 1'b1;
            i_host_we    = 1'($urandom_range(0, 1));
            i_host_addr  = 13'($urandom_range(0, NCELLS + 99));
            i_host_wdata = 16'($urandom);
        end else begin
            i_host_valid = 1'b0;
        end
    endtask

    task automatic cyc(input int h, input int v);
        @(posedge clk_i);
        #1;
        i_hcount = 10'(h);
        i_vcount = 10'(v);
        if (rand_host) host_gen();
    endtask

    task automatic run_lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++)
            for (int h = 0; h < H_TOTAL; h++) cyc(h, v);
    endtask

    initial begin
        bit found;
        for (int a = 0; a < 8192; a++) begin
            ram[a] = 16'(a);
            model_mem[a] = a;
            fetched_val[a] = 0;
        end
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Idle lines with hand-computed expectations.
        for (int v = 0; v <= 9; v++) begin
            for (int h = 0; h < H_TOTAL; h++) begin
                cyc(h, v);
                #2;
                if (v == 8 && h >= 16 && h <= 23) begin
                    chk("pin_char82",  32'(o_char),       32'h52);
                    chk("pin_valid82", 32'(o_cell_valid), 32'd1);
                end
                if (v == 7 && h == H_TOTAL - 6) begin
                    chk("pin_wrap_addr",  32'(o_ram_addr),   32'd80);
                    chk("pin_wrap_ready", 32'(o_host_ready), 32'd0);
                end
                if (v == 8 && h == 0) chk("pin_char80", 32'(o_char), 32'h50);
            end
        end

        // Directed host traffic on line 10.
        for (int h = 0; h < H_TOTAL; h++) begin
            cyc(h, 10);
            if (h == 10) begin
                i_host_valid = 1'b1; i_host_we = 1'b1;
                i_host_addr = 13'd5; i_host_wdata = 16'hABCD;
                #2;
                chk("wr_slot_ready", 32'(o_host_ready), 32'd0);
                chk("wr_slot_we",    32'(o_ram_we),     32'd0);
            end else if (h == 11) begin
                #2;
                chk("wr_ready", 32'(o_host_ready), 32'd1);
                chk("wr_we",    32'(o_ram_we),     32'd1);
                chk("wr_addr",  32'(o_ram_addr),   32'd5);
                chk("wr_data",  32'(o_ram_wdata),  32'hABCD);
            end else if (h == 12) begin
                i_host_valid = 1'b0;
            end else if (h == 40) begin
                i_host_valid = 1'b1; i_host_we = 1'b0; i_host_addr = 13'd5;
                #2;
                chk("rd_ready", 32'(o_host_ready), 32'd1);
            end else if (h == 41) begin
                i_host_valid = 1'b0;
                #2;
                chk("rd_rvalid", 32'(o_host_rvalid), 32'd1);
                chk("rd_rdata",  32'(o_host_rdata),  32'hABCD);
            end else if (h == 60) begin
                i_host_valid = 1'b1; i_host_we = 1'b1;
                i_host_addr = 13'd4800; i_host_wdata = 16'h1234;
                #2;
                chk("oor_wr_ready", 32'(o_host_ready), 32'd1);
                chk("oor_wr_we",    32'(o_ram_we),     32'd0);
            end else if (h == 61) begin
                i_host_we = 1'b0;
                #2;
                chk("oor_rd_ready", 32'(o_host_ready), 32'd1);
                chk("oor_rd_we",    32'(o_ram_we),     32'd0);
            end else if (h == 62) begin
                i_host_valid = 1'b0;
                #2;
                chk("oor_rvalid", 32'(o_host_rvalid), 32'd1);
                chk("oor_rdata",  32'(o_host_rdata),  32'd0);
            end
        end

        // Random host traffic over visible, blanking and frame-wrap lines.
        rand_host = 1'b1;
        run_lines(11, 28);
        for (int v = 476; v <= 491; v++) begin
            for (int h = 0; h < H_TOTAL; h++) begin
                cyc(h, v);
                #2;
                if (v == 490 && h == 650) begin
                    chk("blank_ready", 32'(o_host_ready), 32'd1);
                    chk("blank_cv",    32'(o_cell_valid), 32'd0);
                end
            end
        end
        run_lines(521, 524);
        run_lines(0, 3);

        // Reset one clock after a host read accept.
        rand_host = 1'b0;
        i_host_valid = 1'b0;
        for (int h = 0; h < 20; h++) cyc(h, 4);
        cyc(20, 4);
        i_host_valid = 1'b1; i_host_we = 1'b0; i_host_addr = 13'd7;
        #2;
        chk("rst_rd_accept", 32'(o_host_ready), 32'd1);
        cyc(21, 4);
        rst_i = 1'b1;
        i_host_valid = 1'b0;
        #2;
        chk("rst_rd_rvalid", 32'(o_host_rvalid), 32'd0);
        chk("rst_rd_char",   32'(o_char),        32'd0);
        cyc(22, 4);
        cyc(23, 4);
        rst_i = 1'b0;
        found = 1'b0;
        for (int n = 24; n < 24 + H_TOTAL && !found; n++) begin
            cyc(n % H_TOTAL, 4 + n / H_TOTAL);
            #2;
            if (o_cell_valid) found = 1'b1;
        end
        chk("cell_valid_after_reset", 32'(found), 32'd1);
        run_lines(5, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
